// File: rtl/mac6_dot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mac6_dot_ctrl
// Brief    : Sequencer for a saturating signed 6-bit dot product on one MAC6.
// Revision : 1.0 - initial release
// ============================================================================
module mac6_dot_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  len,
    input  logic [11:0] init_acc,
    input  logic        abort,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_a,
    input  logic [5:0]  in_b,
    output logic [5:0]  mac_a,
    output logic [5:0]  mac_b,
    output logic [1:0]  mac_mode,
    output logic [11:0] mac_acc,
    input  logic [12:0] mac_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [11:0] res_data,
    output logic        res_ovf,
    output logic        busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0]  C_MODE_MAC = 2'b00;
    localparam logic [11:0] C_SAT_POS  = 12'h7FF;
    localparam logic [11:0] C_SAT_NEG  = 12'h800;

    logic [1:0]  r_state;
    logic [11:0] r_acc;
    logic [3:0]  r_cnt;
    logic [3:0]  r_len_q;
    logic        r_ovf;

    logic        w_sat_hit;
    logic [11:0] w_sat_val;
    logic        w_last;

    // mac_out is exact in 13 bits; disagreeing top bits mean the 12-bit range was left.
    assign w_sat_hit = mac_out[12] ^ mac_out[11];
    assign w_sat_val = w_sat_hit ? (mac_out[12] ? C_SAT_NEG : C_SAT_POS) : mac_out[11:0];
    assign w_last    = (r_cnt == (r_len_q - 4'd1));

    assign mac_a     = in_a;
    assign mac_b     = in_b;
    assign mac_mode  = C_MODE_MAC;
    assign mac_acc   = r_acc;

    assign in_ready  = (r_state == S_RUN);
    assign res_valid = (r_state == S_DONE);
    assign res_data  = r_acc;
    assign res_ovf   = r_ovf;
    assign busy      = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_acc   <= 12'd0;
            r_cnt   <= 4'd0;
            r_len_q <= 4'd0;
            r_ovf   <= 1'b0;
        end else if (abort) begin
            r_state <= S_IDLE;
            r_acc   <= 12'd0;
            r_cnt   <= 4'd0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc   <= init_acc;
                        r_len_q <= len;
                        r_cnt   <= 4'd0;
                        r_ovf   <= 1'b0;
                        r_state <= (len != 4'd0) ? S_RUN : S_DONE;
                    end
                end
                S_RUN: begin
                    if (in_valid) begin
                        r_acc <= w_sat_val;
                        r_cnt <= r_cnt + 4'd1;
                        r_ovf <= r_ovf | w_sat_hit;
                        if (w_last) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mac6_dot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac6_dot_ctrl
// Brief    : Self-checking bench for mac6_dot_ctrl with a behavioural MAC6.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac6_dot_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  len;
    logic [11:0] init_acc;
    logic        abort;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_a;
    logic [5:0]  in_b;
    logic [5:0]  mac_a;
    logic [5:0]  mac_b;
    logic [1:0]  mac_mode;
    logic [11:0] mac_acc;
    logic [12:0] mac_out;
    logic        res_valid;
    logic        res_ready;
    logic [11:0] res_data;
    logic        res_ovf;
    logic        busy;

    int n_tests;
    int n_fail;

    logic signed [5:0] op_a [16];
    logic signed [5:0] op_b [16];
    logic [11:0]       last_data;
    logic              last_ovf;

    mac6_dot_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .len      (len),
        .init_acc (init_acc),
        .abort    (abort),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .mac_a    (mac_a),
        .mac_b    (mac_b),
        .mac_mode (mac_mode),
        .mac_acc  (mac_acc),
        .mac_out  (mac_out),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .res_ovf  (res_ovf),
        .busy     (busy)
    );

    // Behavioural MAC6 in A*B+ACC mode, operands and ACC sign-extended to 13 bits.
    logic [12:0] w_ea;
    logic [12:0] w_eb;
    assign w_ea    = {{7{mac_a[5]}}, mac_a};
    assign w_eb    = {{7{mac_b[5]}}, mac_b};
    assign mac_out = 13'(w_ea * w_eb) + {mac_acc[11], mac_acc};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // stall: 0 = valid every cycle, 1 = valid on alternate cycles, 2 = random gaps.
    task automatic run_job(input logic [11:0] init, input int n, input int stall, input int hold);
        int acc_m;
        int ovf_m;
        int k;
        int cyc;
        bit vld;
        logic [11:0] held;
        acc_m = int'($signed(init));
        ovf_m = 0;
        start    = 1'b1;
        len      = 4'(n);
        init_acc = init;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        k   = 0;
        cyc = 0;
        while (k < n && cyc < 400) begin
            if (stall == 0)      vld = 1'b1;
            else if (stall == 1) vld = (cyc % 2) == 1;
            else                 vld = $urandom_range(0, 99) >= 30;
            in_valid = vld;
            in_a     = op_a[k];
            in_b     = op_b[k];
            if (vld) begin
                chk("in_ready_run", {31'd0, in_ready}, 32'd1);
                chk("mac_acc_run", {20'd0, mac_acc}, {20'd0, 12'(acc_m)});
            end
            @(negedge clk);
            if (vld) begin
                acc_m = acc_m + int'(op_a[k]) * int'(op_b[k]);
                if (acc_m > 2047) begin
                    acc_m = 2047;
                    ovf_m = 1;
                end else if (acc_m < -2048) begin
                    acc_m = -2048;
                    ovf_m = 1;
                end
                k++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        if (k < n) chk("accept_timeout", 32'(k), 32'(n));
        chk("res_valid_timing", {31'd0, res_valid}, 32'd1);
        chk("in_ready_done", {31'd0, in_ready}, 32'd0);
        chk("res_data", {20'd0, res_data}, {20'd0, 12'(acc_m)});
        chk("res_ovf", {31'd0, res_ovf}, 32'(ovf_m));
        held = res_data;
        for (int h = 0; h < hold; h++) begin
            start    = 1'b1;
            in_valid = 1'b1;
            @(negedge clk);
            chk("hold_valid", {31'd0, res_valid}, 32'd1);
            chk("hold_data", {20'd0, res_data}, {20'd0, held});
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        last_data = res_data;
        last_ovf  = res_ovf;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("post_handshake_valid", {31'd0, res_valid}, 32'd0);
        chk("post_handshake_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = 4'd0;
        init_acc  = 12'd0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        in_a      = 6'd0;
        in_b      = 6'd0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res_data", {20'd0, res_data}, 32'd0);
        chk("rst_res_ovf", {31'd0, res_ovf}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mac_acc", {20'd0, mac_acc}, 32'd0);
        chk("rst_mac_mode", {30'd0, mac_mode}, 32'd0);

        in_a = 6'd5;
        in_b = 6'h3D;
        #1;
        chk("mac_a_pass", {26'd0, mac_a}, 32'h05);
        chk("mac_b_pass", {26'd0, mac_b}, 32'h3D);

        // Basic: 12 - 10 - 7 = -5
        op_a[0] = 6'sd3;  op_b[0] = 6'sd4;
        op_a[1] = -6'sd2; op_b[1] = 6'sd5;
        op_a[2] = 6'sd7;  op_b[2] = -6'sd1;
        run_job(12'h000, 3, 0, 0);
        chk("basic_const", {20'd0, last_data}, 32'hFFB);
        chk("basic_ovf_const", {31'd0, last_ovf}, 32'd0);

        op_a[0] = 6'sd5; op_b[0] = 6'sd5;
        run_job(12'h7F0, 1, 0, 0);
        chk("sat_pos_const", {20'd0, last_data}, 32'h7FF);
        chk("sat_pos_ovf", {31'd0, last_ovf}, 32'd1);

        op_a[0] = -6'sd32; op_b[0] = 6'sd31;
        op_a[1] = 6'sd1;   op_b[1] = 6'sd1;
        run_job(12'h800, 2, 0, 0);
        chk("sat_neg_const", {20'd0, last_data}, 32'h801);
        chk("sat_neg_sticky", {31'd0, last_ovf}, 32'd1);

        run_job(12'h123, 0, 0, 0);
        chk("zero_len_const", {20'd0, last_data}, 32'h123);

        for (int i = 0; i < 4; i++) begin
            op_a[i] = 6'sd1;
            op_b[i] = 6'sd1;
        end
        run_job(12'h000, 4, 1, 5);
        chk("bp_const", {20'd0, last_data}, 32'h004);

        // Abort after two accepts, with start and in_valid also high.
        start = 1'b1; len = 4'd4; init_acc = 12'h010;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; in_a = 6'd3; in_b = 6'd3;
        repeat (2) @(negedge clk);
        chk("abort_pre_acc", {20'd0, mac_acc}, 32'h022);
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0; in_valid = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
        chk("abort_mac_acc", {20'd0, mac_acc}, 32'd0);
        chk("abort_ovf", {31'd0, res_ovf}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_result", {31'd0, res_valid}, 32'd0);
        end
        op_a[0] = 6'sd2; op_b[0] = 6'sd3;
        run_job(12'h000, 1, 0, 0);
        chk("after_abort_const", {20'd0, last_data}, 32'h006);

        // Reset mid-RUN, after a saturating term.
        start = 1'b1; len = 4'd4; init_acc = 12'h7F0;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; in_a = 6'd5; in_b = 6'd5;
        @(negedge clk);
        rst_n = 1'b0; abort = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; abort = 1'b0; in_valid = 1'b0;
        chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_mid_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_mid_res_data", {20'd0, res_data}, 32'd0);
        chk("rst_mid_res_ovf", {31'd0, res_ovf}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_mac_acc", {20'd0, mac_acc}, 32'd0);

        for (int j = 0; j < 1000; j++) begin
            int n;
            n = $urandom_range(0, 15);
            for (int i = 0; i < 16; i++) begin
                op_a[i] = 6'($urandom);
                op_b[i] = 6'($urandom);
            end
            run_job(12'($urandom), n, 2, $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mac6_dot_ctrl.md
# mac6_dot_ctrl

Sequencing controller that drives the combinational `MAC6` datapath to compute a saturating signed dot product over a stream of 6-bit operand pairs. The block holds the 12-bit accumulator register and feeds it back through MAC6's `ACC` port. It counts a programmed number of terms and presents the final result on a valid/ready output port. It sits between an operand source (FIFO or sequencer) and a result consumer, with one MAC6 instance as its arithmetic resource.

## Interface
- No parameters. Widths are fixed by MAC6: 6-bit operands, 12-bit accumulator, 13-bit MAC result.
- `clk`  in  1  single clock, all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  begin a job; sampled only in IDLE
- `len`  in  4  number of terms, 0..15; sampled with `start`
- `init_acc`  in  12  signed initial accumulator; sampled with `start`
- `abort`  in  1  cancel current job
- `in_valid`  in  1  operand pair valid
- `in_ready`  out  1  pair accepted when `in_valid & in_ready`
- `in_a`, `in_b`  in  6 each  signed operands
- `mac_a`, `mac_b`  out  6 each  to MAC6 `A`/`B`; equal to `in_a`/`in_b` (combinational)
- `mac_mode`  out  2  to MAC6 `MODE`; constant 2'b00 (A*B+ACC)
- `mac_acc`  out  12  to MAC6 `ACC`; equal to accumulator register
- `mac_out`  in  13  from MAC6 `OUT`; combinational, same cycle
- `res_valid`  out  1  result available
- `res_ready`  in  1  consumer accepts result
- `res_data`  out  12  signed result (accumulator)
- `res_ovf`  out  1  sticky: at least one term saturated this job
- `busy`  out  1  high in RUN or DONE

## Operation
- States: IDLE, RUN, DONE. Registers: `acc[11:0]`, `cnt[3:0]`, `len_q[3:0]`, `ovf`.
- IDLE: `start=1` loads `acc<=init_acc`, `len_q<=len`, `cnt<=0`, `ovf<=0`. The next state is RUN if `len!=0`, else DONE.
- RUN: `in_ready=1`. On accept:
  - `acc<=sat(mac_out)`.
  - `cnt<=cnt+1`.
  - `ovf<=ovf|sat_hit`.
  - If `cnt==len_q-1`, the next state is DONE.
  - No accept means all state is held.
- DONE: `res_valid=1`, `res_data=acc`, `res_ovf=ovf`, and all three are stable until `res_ready`. `res_valid & res_ready` moves to IDLE.
- Saturation:
  - MAC6 sign-extends `ACC`, and the product magnitude is at most 1024, so `mac_out` is exact.
  - `sat_hit = mac_out[12]^mac_out[11]`.
  - On a hit: `mac_out[12]=0` gives 12'h7FF, `mac_out[12]=1` gives 12'h800.
  - Otherwise the result is `mac_out[11:0]`.
- `abort=1` in any state goes to IDLE next cycle. No result is produced, and `acc`, `cnt` and `ovf` are cleared. Abort has priority over `start`, input accept and result handshake in the same cycle.
- `start` in RUN or DONE is ignored.
- `in_ready=0` outside RUN. `in_valid` outside RUN is ignored.

## Timing
- Reset (`rst_n=0` at an edge): state IDLE, `acc=0`, `cnt=0`, `len_q=0`, `ovf=0`. This gives `in_ready=0`, `res_valid=0`, `res_data=0`, `res_ovf=0`, `busy=0`, `mac_acc=0`, `mac_mode=2'b00`.
- Reset mid-job has the same effect as reset from idle. It overrides abort and every other input.
- One term per cycle at full throughput. A job of N terms with no stalls:
  - `start` at edge 0.
  - Terms accepted at edges 1..N.
  - `res_valid` high in the cycle after edge N.
- `len=0`: `res_valid` is high in the cycle after the `start` edge, with `res_data=init_acc`.
- Earliest next `start` is in the cycle after the result handshake (IDLE), giving one idle bubble per job.
- Combinational paths `in_a`→`mac_out`→`acc` D-input lie within one cycle. No other combinational input-to-output paths exist except `mac_a`/`mac_b` passthrough.

## Test plan
- Basic: `init_acc=0`, `len=3`, pairs (3,4), (-2,5), (7,-1). Required: `res_data=12'hFFB` (-5), `res_ovf=0`, `res_valid` in the cycle after the 3rd accept.
- Saturation:
  - `init_acc=12'h7F0` (2032), `len=1`, pair (5,5) → `res_data=12'h7FF`, `res_ovf=1`.
  - `init_acc=12'h800`, `len=2`, pairs (-32,31) then (1,1) → first term saturates to 12'h800 and sets `ovf`; second gives 12'h801. `res_ovf` stays 1 (sticky).
- Zero length: `start` with `len=0`, `init_acc=12'h123` → `res_valid` next cycle, `res_data=12'h123`, `in_ready` never high.
- Backpressure:
  - `len=4`, all pairs (1,1), with `in_valid` low on alternate cycles → result 4, accepted only on valid cycles.
  - Hold `res_ready=0` for 5 cycles → `res_valid` and `res_data` stable, `start` pulses ignored.
- Abort/reset: `len=4`, abort after 2 accepts → IDLE next cycle, `res_valid` never asserted. Then a new job with `len=1`, (2,3), `init_acc=0` → 6. Repeat with `rst_n=0` mid-RUN → all outputs at reset values.
- Integration: connect to a real MAC6 instance and run 1000 random jobs. Check each result against a saturating reference model.
